// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone adder front end: widths, skid-buffer state
// and the propagate/generate entry carried through the skid buffer.
package ks_pkg;

  localparam int KS_WIDTH = 32;
  localparam int KS_TAG_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pg_state_t;

  typedef struct packed {
    logic [KS_WIDTH-1:0] p;
    logic [KS_WIDTH-1:0] g;
    logic                cin;
    logic [KS_TAG_W-1:0] tag;
  } pg_entry_t;

endpackage

// File: rtl/pg_cell.sv
// One bit of propagate/generate; the bit-0 instance also folds carry-in into
// its generate so the prefix tree needs no separate cin input.
module pg_cell #(
  parameter bit FOLD_CIN = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic p,
  output logic g
);

  assign p = a ^ b;
  assign g = (a & b) | (FOLD_CIN & p & cin);

endmodule

// File: rtl/ks_pg_stage.sv
// Registered propagate/generate stage feeding level1 of the prefix tree,
// with a two-entry skid buffer on a valid/ready handshake.
module ks_pg_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int TAG_W = KS_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_list,
  output logic [WIDTH-1:0] g_list,
  output logic             out_cin,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      xfer_count
);

  pg_state_t        state;
  pg_entry_t        main_entry;
  pg_entry_t        skid_entry;
  pg_entry_t        incoming;
  logic [WIDTH-1:0] p_vec;
  logic [WIDTH-1:0] g_vec;
  logic             in_fire;
  logic             out_fire;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pg
    pg_cell #(.FOLD_CIN(i == 0)) u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin ((i == 0) ? cin : 1'b0),
      .p   (p_vec[i]),
      .g   (g_vec[i])
    );
  end

  // Handshake flags decode from registered state only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state != TWO) & ~rst;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Pack the freshly computed bits into a buffer entry
  always_comb begin
    incoming     = '0;
    incoming.p   = p_vec;
    incoming.g   = g_vec;
    incoming.cin = cin;
    incoming.tag = in_tag;
  end

  // Skid buffer occupancy, entry capture and output transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_entry <= '0;
      skid_entry <= '0;
      xfer_count <= 16'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_entry <= incoming;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_entry <= incoming;
          end else if (in_fire) begin
            skid_entry <= incoming;
            state      <= TWO;
          end else if (out_fire) begin
            state      <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_entry <= skid_entry;
            state      <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
      if (out_fire) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

  assign p_list  = main_entry.p;
  assign g_list  = main_entry.g;
  assign out_cin = main_entry.cin;
  assign out_tag = main_entry.tag;

endmodule

// File: tb/tb_ks_pg_stage.sv
// Self-checking bench for ks_pg_stage: a queue-based model of the buffer
// contents predicts handshake flags, payload and transfer count every cycle.
module tb_ks_pg_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p_list;
  logic [31:0] g_list;
  logic        out_cin;
  logic [3:0]  out_tag;
  logic [15:0] xfer_count;

  typedef struct {
    logic [31:0] p;
    logic [31:0] g;
    logic        cin;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_count;
  int          n_cmp = 0;
  int          n_err = 0;

  ks_pg_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p_list     (p_list),
    .g_list     (g_list),
    .out_cin    (out_cin),
    .out_tag    (out_tag),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // Expected entry from the adder's definition: propagate = sum bit without
  // carry, generate = carry out; bit 0 uses the true carry out of a0+b0+cin.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mc, input logic [3:0] mt);
    exp_t e;
    int   s0;
    e.p   = ma ^ mb;
    e.g   = ma & mb;
    s0    = int'(ma[0]) + int'(mb[0]) + int'(mc);
    e.g[0] = (s0 >= 2);
    e.cin = mc;
    e.tag = mt;
    return e;
  endfunction

  // One clock: model decides the fires from its own occupancy, then updates.
  task automatic advance();
    bit   ofire;
    bit   ifire;
    exp_t e;
    ofire = !rst && (sb.size() != 0) && out_ready;
    ifire = !rst && in_valid && (sb.size() < 2);
    e     = model(a, b, cin, in_tag);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      exp_count = 0;
    end else begin
      if (ofire) begin
        void'(sb.pop_front());
        exp_count = (exp_count + 1) % 65536;
      end
      if (ifire) sb.push_back(e);
    end
    #1;
  endtask

  task automatic set_beat(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic [3:0] tt);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    cin      = tc;
    in_tag   = tt;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; cin = 1'b0; in_tag = 4'd0;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    n_cmp++;
    if (xfer_count !== 16'd0) begin n_err++; $display("FAIL reset_xfer got=%0d exp=0", xfer_count); end
    n_cmp++;
    if ({p_list, g_list, out_cin, out_tag} !== 69'd0) begin
      n_err++; $display("FAIL reset_payload got=%h/%h/%b/%h exp=0", p_list, g_list, out_cin, out_tag);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_beat(32'h0000_00FF, 32'h0000_0F01, 1'b1, 4'd5);
    advance();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_cmp++;
    if (p_list !== 32'h0000_0FFE) begin n_err++; $display("FAIL single_p got=%h exp=00000ffe", p_list); end
    n_cmp++;
    if (g_list !== 32'h0000_0001) begin n_err++; $display("FAIL single_g got=%h exp=00000001", g_list); end
    n_cmp++;
    if (out_cin !== 1'b1 || out_tag !== 4'd5) begin
      n_err++; $display("FAIL single_cin_tag got=%b/%h exp=1/5", out_cin, out_tag);
    end
    advance();
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_count !== exp_count[15:0]) begin
      n_err++; $display("FAIL single_drain got=%b/%0d exp=0/%0d", out_valid, xfer_count, exp_count);
    end
  endtask

  task automatic test_carry_fold();
    out_ready = 1'b1;
    set_beat(32'h1, 32'h0, 1'b1, 4'd6);
    advance();
    n_cmp++;
    if (p_list !== 32'h1 || g_list !== 32'h1) begin
      n_err++; $display("FAIL fold_cin1 got=%h/%h exp=1/1", p_list, g_list);
    end
    set_beat(32'h1, 32'h0, 1'b0, 4'd7);
    advance();
    in_valid = 1'b0;
    n_cmp++;
    if (p_list !== 32'h1 || g_list !== 32'h0 || out_tag !== 4'd7) begin
      n_err++; $display("FAIL fold_cin0 got=%h/%h/%h exp=1/0/7", p_list, g_list, out_tag);
    end
    advance();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_tags[6];
    logic       exp_rdy[6];
    logic       exp_vld[6];
    exp_tags = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3};
    exp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_beat($urandom, $urandom, 1'($urandom), 4'd1);
        1: set_beat($urandom, $urandom, 1'($urandom), 4'd2);
        2: set_beat($urandom, $urandom, 1'($urandom), 4'd3);
        3: out_ready = 1'b1;
        5: in_valid = 1'b0;
        default: ;
      endcase
      advance();
      n_cmp++;
      if (out_valid !== exp_vld[i] || in_ready !== exp_rdy[i]) begin
        n_err++; $display("FAIL bp_flags[%0d] got=%b/%b exp=%b/%b", i, out_valid, in_ready, exp_vld[i], exp_rdy[i]);
      end
      if (exp_vld[i]) begin
        n_cmp++;
        if (out_tag !== exp_tags[i] || sb.size() == 0 || p_list !== sb[0].p || g_list !== sb[0].g || out_cin !== sb[0].cin) begin
          n_err++; $display("FAIL bp_payload[%0d] got tag=%h p=%h g=%h exp tag=%h", i, out_tag, p_list, g_list, exp_tags[i]);
        end
      end
    end
    n_cmp++;
    if (xfer_count !== exp_count[15:0]) begin n_err++; $display("FAIL bp_xfer got=%0d exp=%0d", xfer_count, exp_count); end
  endtask

  task automatic test_reset_two();
    out_ready = 1'b0;
    set_beat($urandom, $urandom, 1'b1, 4'd9);
    advance();
    set_beat($urandom, $urandom, 1'b0, 4'd10);
    advance();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL two_in_ready got=%b exp=0", in_ready); end
    rst = 1'b1; in_valid = 1'b0;
    advance();
    rst = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_count !== 16'd0 || p_list !== 32'd0) begin
      n_err++; $display("FAIL two_reset got=%b/%0d/%h exp=0/0/0", out_valid, xfer_count, p_list);
    end
    for (int i = 0; i < 3; i++) begin
      advance();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL two_no_ghost[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_beat($urandom, $urandom, 1'($urandom), 4'($urandom));
      advance();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || sb.size() == 0) begin
        n_err++; $display("FAIL b2b_flags[%0d] got=%b/%b exp=1/1", i, out_valid, in_ready);
      end else begin
        n_cmp++;
        if (p_list !== sb[0].p || g_list !== sb[0].g || out_cin !== sb[0].cin || out_tag !== sb[0].tag) begin
          n_err++; $display("FAIL b2b_payload[%0d] got=%h/%h/%b/%h exp=%h/%h/%b/%h", i,
                            p_list, g_list, out_cin, out_tag, sb[0].p, sb[0].g, sb[0].cin, sb[0].tag);
        end
      end
    end
    in_valid = 1'b0;
    advance();
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_count !== 16'd100) begin
      n_err++; $display("FAIL b2b_xfer got=%b/%0d exp=0/100", out_valid, xfer_count);
    end
  endtask

  initial begin
    exp_count = 0;
    test_reset();
    test_single();
    test_carry_fold();
    test_backpressure();
    test_reset_two();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ks_pg_stage.md
# ks_pg_stage

Registered propagate/generate front end of the Kogge-Stone adder. It accepts operand pairs `a`, `b` plus `cin` over a valid/ready handshake and computes `p_list = a ^ b` and `g_list = a & b`, with carry-in folded into bit 0. It buffers the results in a two-entry skid buffer and presents them to `level1` as registered `p_list`/`g_list` buses. It also forwards `cin` and a sideband tag for the sum stage.

## Interface
- `WIDTH`, 32: operand width; must equal the prefix-tree width (`level1` is 32).
- `TAG_W`, 4: sideband tag width, carried unmodified.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: stage can accept a beat.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry in.
- `in_tag` in TAG_W: sideband.
- `out_valid` out 1: `p_list`/`g_list` beat valid.
- `out_ready` in 1: downstream (prefix tree/pipeline register) accepts.
- `p_list` out WIDTH: registered propagate bits, feeds `level1.p_list`.
- `g_list` out WIDTH: registered generate bits with cin folded into bit 0, feeds `level1.g_list`.
- `out_cin` out 1: registered cin, needed for sum bit 0.
- `out_tag` out TAG_W: registered tag.
- `xfer_count` out 16: count of output transfers, wraps 0xFFFF→0.

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- PG compute, combinational on inputs before capture:
  - `p[i] = a[i]^b[i]` for all i.
  - `g[i] = a[i]&b[i]` for i≥1.
  - `g[0] = (a[0]&b[0]) | (p[0]&cin)`.
- Entry payload: `{p, g, cin, tag}`. Two entries: MAIN (drives outputs) and SKID.
- State machine, states EMPTY, ONE, TWO:
  - EMPTY: `in_fire` → ONE, MAIN ← payload.
  - ONE, `in_fire & !out_fire` → TWO, SKID ← payload.
  - ONE, `in_fire & out_fire` → ONE, MAIN ← payload.
  - ONE, `!in_fire & out_fire` → EMPTY.
  - ONE, neither → ONE, hold.
  - TWO: `in_ready`=0. `out_fire` → ONE, MAIN ← SKID; otherwise hold.
- `out_valid = (state != EMPTY)`. `in_ready = (state != TWO) & !rst`. Both are decoded from registered state only; no combinational path from `out_ready` to `in_ready`.
- Outputs are stable while `out_valid & !out_ready`: no payload change until `out_fire`.
- `xfer_count` increments by 1 on each `out_fire`.
- Inputs with `in_valid`=0 are ignored. `a`/`b` changes without a fire have no effect.

## Timing
- Latency: beat accepted in cycle N appears at `out_valid` in cycle N+1 when the stage was EMPTY, or when ONE with `out_fire` in N.
- Throughput: one beat per cycle with `out_ready` held high.
- Backpressure: a single stall cycle absorbs one extra beat in SKID. `in_ready` drops the cycle after entering TWO.
- Reset values (applied at the edge where `rst`=1):
  - state EMPTY, `out_valid` 0.
  - `p_list`, `g_list`, `out_cin`, `out_tag` all 0; `xfer_count` 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-operation discards both entries; no beat is emitted after reset.
- Simultaneous `in_fire` and `out_fire` in ONE: the new payload replaces MAIN in the same edge, with no bubble.

## Structure
- Package `ks_pkg`:
  - `KS_WIDTH` = 32.
  - State enum `pg_state_t` {EMPTY, ONE, TWO}.
  - Packed struct `pg_entry_t` {p, g, cin, tag}, parameterised by width via localparams.
- Sub-module `pg_cell`: per-bit `p`/`g` generation plus the cin-folding cell for bit 0; instantiated WIDTH times.
- Skid buffer and state machine live in `ks_pg_stage` itself.

## Test plan
- Reset release: hold `rst` 3 cycles → `out_valid`=0, `in_ready`=0 during reset, `in_ready`=1 next cycle, `xfer_count`=0.
- Single beat: `a`=0x0000_00FF, `b`=0x0000_0F01, `cin`=1, `out_ready`=1 → next cycle `p_list`=0x0000_0FFE, `g_list`=0x0000_0001, `out_cin`=1.
- Carry fold: `a`=0x1, `b`=0x0, `cin`=1 → `p_list`=0x1, `g_list`=0x1. Same with `cin`=0 → `g_list`=0x0.
- Backpressure: stream tags 1,2,3 while `out_ready`=0 → tags 1,2 captured, `in_ready`=0 after the 2nd accept. Release `out_ready` → outputs tag 1, then tag 2, then tag 3 accepted; no loss or duplication.
- Full throughput: 100 back-to-back random beats with `out_ready`=1 → one output per cycle, values match the `a^b` / `a&b` model, `xfer_count`=100.
- Reset with TWO occupied: assert `rst` 1 cycle → `out_valid`=0, buffered beats never appear, `xfer_count`=0.
